onehot_encoder_8x3_stream: RTL and testbench

Sequential 8-to-3 encoder: the inverse companion of the team's 3x8 decoder. It accepts an 8-bit request vector over a valid/ready handshake and emits, one beat at a time, the 3-bit binary index of every set bit, in scan order. Each code beat travels over its own valid/ready handshake. It sits between event/flag sources and downstream logic that consumes 3-bit select codes, such as the 3x8 decoder itself.

---
 rtl/onehot_encoder_8x3_stream.sv | 119 +++++++++++
 tb/tb_onehot_encoder_8x3_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_8x3_stream.sv
// Sequential 8-to-3 encoder: captures an 8-bit request vector and streams the
// binary index of every set bit, one handshaked beat at a time, in scan order.
module onehot_encoder_8x3_stream #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [2:0] code,
    output logic       code_none,
    output logic       code_last,
    output logic [3:0] code_count,
    output logic       code_valid,
    input  logic       code_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] pend;
    logic [3:0] cnt;

    logic [3:0] req_pc;
    logic [2:0] cur_idx;
    logic [7:0] pend_next;
    logic [2:0] next_idx;
    logic [3:0] next_pc;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Priority encode in scan order; the winning bit is the one written last.
    function automatic logic [2:0] first_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        if (LSB_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (v[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        req_pc    = popcount8(req);
        cur_idx   = first_index(pend);
        pend_next = pend & ~(8'b0000_0001 << cur_idx);
        next_idx  = first_index(pend_next);
        next_pc   = popcount8(pend_next);
    end

    assign code_count = cnt;

    // Beat outputs are registered and precomputed from the vector left after
    // the current transfer, so nothing on the output side sees req or code_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend       <= '0;
            cnt        <= '0;
            req_ready  <= 1'b1;
            code_valid <= 1'b0;
            code       <= '0;
            code_none  <= 1'b0;
            code_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state      <= EMIT;
                        pend       <= req;
                        cnt        <= req_pc;
                        req_ready  <= 1'b0;
                        code_valid <= 1'b1;
                        code       <= first_index(req);
                        code_none  <= (req == 8'h00);
                        code_last  <= (req_pc <= 4'd1);
                    end
                end
                EMIT: begin
                    if (code_ready) begin
                        pend <= pend_next;
                        if (code_last) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            req_ready  <= 1'b1;
                            code_valid <= 1'b0;
                            code       <= '0;
                            code_none  <= 1'b0;
                            code_last  <= 1'b0;
                        end else begin
                            code      <= next_idx;
                            code_last <= (next_pc == 4'd1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_encoder_8x3_stream.sv
// Bench for onehot_encoder_8x3_stream: both scan orders run side by side on the
// same stimulus and are compared every cycle against an index-list reference.
module tb_onehot_encoder_8x3_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       req_valid;
    logic       code_ready;

    logic       req_ready_a, code_none_a, code_last_a, code_valid_a;
    logic [2:0] code_a;
    logic [3:0] code_count_a;
    logic       req_ready_b, code_none_b, code_last_b, code_valid_b;
    logic [2:0] code_b;
    logic [3:0] code_count_b;

    logic [9:0] obs_a, obs_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    onehot_encoder_8x3_stream #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .req(req), .req_valid(req_valid),
        .req_ready(req_ready_a), .code(code_a), .code_none(code_none_a),
        .code_last(code_last_a), .code_count(code_count_a),
        .code_valid(code_valid_a), .code_ready(code_ready)
    );

    onehot_encoder_8x3_stream #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .req(req), .req_valid(req_valid),
        .req_ready(req_ready_b), .code(code_b), .code_none(code_none_b),
        .code_last(code_last_b), .code_count(code_count_b),
        .code_valid(code_valid_b), .code_ready(code_ready)
    );

    assign obs_a = {code_valid_a, code_a, code_none_a, code_last_a, code_count_a};
    assign obs_b = {code_valid_b, code_b, code_none_b, code_last_b, code_count_b};

    function automatic int beats_of(input logic [7:0] v);
        return ($countones(v) == 0) ? 1 : $countones(v);
    endfunction

    // Expected {valid, code, none, last, count} for beat n of vector v.
    function automatic logic [9:0] exp_out(input logic [7:0] v, input bit lsb, input int n);
        int idx[$];
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                if (lsb) idx.push_back(i);
                else     idx.push_front(i);
            end
        end
        if (idx.size() == 0) return {1'b1, 3'd0, 1'b1, 1'b1, 4'd0};
        return {1'b1, 3'(idx[n]), 1'b0, (n == idx.size() - 1), 4'(idx.size())};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; req = 8'h00; req_valid = 1'b0; code_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL reset_held got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL reset_released got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
    endtask

    task automatic test_single();
        logic [7:0] v;
        int n;
        v = 8'b0000_0100; n = 0;
        code_ready = 1'b1;
        req = v; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && n < 1; cyc++) begin
            checks++;
            if (obs_a !== exp_out(v, 1'b1, n)) begin
                errors++;
                $display("FAIL single_lsb beat=%0d got=%h want=%h", n, obs_a, exp_out(v, 1'b1, n));
            end
            checks++;
            if (obs_b !== exp_out(v, 1'b0, n)) begin
                errors++;
                $display("FAIL single_msb beat=%0d got=%h want=%h", n, obs_b, exp_out(v, 1'b0, n));
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL single_idle got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
    endtask

    task automatic test_multibit();
        logic [7:0] v;
        int n;
        v = 8'b1010_0011; n = 0;
        code_ready = 1'b1;
        req = v; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            checks++;
            if (obs_a !== exp_out(v, 1'b1, n)) begin
                errors++;
                $display("FAIL multibit_lsb beat=%0d got=%h want=%h", n, obs_a, exp_out(v, 1'b1, n));
            end
            checks++;
            if (obs_b !== exp_out(v, 1'b0, n)) begin
                errors++;
                $display("FAIL multibit_msb beat=%0d got=%h want=%h", n, obs_b, exp_out(v, 1'b0, n));
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL multibit_idle got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] v;
        int n;
        v = 8'hFF; n = 0;
        code_ready = 1'b0;
        req = v; req_valid = 1'b1;
        @(negedge clk);
        // A different vector stays offered during EMIT and must wait for IDLE.
        req = 8'h81;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            checks++;
            if (obs_a !== exp_out(v, 1'b1, n)) begin
                errors++;
                $display("FAIL backpressure_lsb beat=%0d got=%h want=%h", n, obs_a, exp_out(v, 1'b1, n));
            end
            checks++;
            if (obs_b !== exp_out(v, 1'b0, n)) begin
                errors++;
                $display("FAIL backpressure_msb beat=%0d got=%h want=%h", n, obs_b, exp_out(v, 1'b0, n));
            end
            code_ready = ~code_ready;
            if (code_ready) n++;
            @(negedge clk);
        end
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL backpressure_idle got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
        v = 8'h81; n = 0;
        code_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && n < 2; cyc++) begin
            checks++;
            if (obs_a !== exp_out(v, 1'b1, n)) begin
                errors++;
                $display("FAIL held_valid_lsb beat=%0d got=%h want=%h", n, obs_a, exp_out(v, 1'b1, n));
            end
            checks++;
            if (obs_b !== exp_out(v, 1'b0, n)) begin
                errors++;
                $display("FAIL held_valid_msb beat=%0d got=%h want=%h", n, obs_b, exp_out(v, 1'b0, n));
            end
            n++;
            @(negedge clk);
        end
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL held_valid_idle got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
    endtask

    task automatic test_zero();
        code_ready = 1'b0;
        req = 8'h00; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        // Stalled first: the zero beat must hold steady.
        for (int cyc = 0; cyc < 2; cyc++) begin
            checks++;
            if ({obs_a, obs_b} !== {exp_out(8'h00, 1'b1, 0), exp_out(8'h00, 1'b0, 0)}) begin
                errors++;
                $display("FAIL zero_beat cyc=%0d got=%h want=%h", cyc, {obs_a, obs_b},
                         {exp_out(8'h00, 1'b1, 0), exp_out(8'h00, 1'b0, 0)});
            end
            if (cyc == 1) code_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL zero_idle got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        v = 8'b0111_0000;
        code_ready = 1'b1;
        req = v; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int n = 0; n < 2; n++) begin
            checks++;
            if ({obs_a, obs_b} !== {exp_out(v, 1'b1, n), exp_out(v, 1'b0, n)}) begin
                errors++;
                $display("FAIL reset_mid_beat beat=%0d got=%h want=%h", n, {obs_a, obs_b},
                         {exp_out(v, 1'b1, n), exp_out(v, 1'b0, n)});
            end
            if (n == 1) code_ready = 1'b0;
            else @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL reset_async got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL reset_mid_quiet got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
        v = 8'b0000_0001;
        code_ready = 1'b1;
        req = v; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({obs_a, obs_b} !== {exp_out(v, 1'b1, 0), exp_out(v, 1'b0, 0)}) begin
            errors++;
            $display("FAIL reset_mid_after got=%h want=%h", {obs_a, obs_b}, {exp_out(v, 1'b1, 0), exp_out(v, 1'b0, 0)});
        end
        @(negedge clk);
        checks++;
        if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
            errors++;
            $display("FAIL reset_mid_idle got=%h want=%h", {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
        end
    endtask

    task automatic test_sweep();
        logic [7:0] v;
        int n, k, dut_beats;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            k = beats_of(v);
            n = 0; dut_beats = 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            code_ready = 1'($urandom_range(0, 1));
            req = v; req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            for (int cyc = 0; cyc < 80 && n < k; cyc++) begin
                checks++;
                if (obs_a !== exp_out(v, 1'b1, n)) begin
                    errors++;
                    $display("FAIL sweep_lsb v=%h beat=%0d got=%h want=%h", v, n, obs_a, exp_out(v, 1'b1, n));
                end
                checks++;
                if (obs_b !== exp_out(v, 1'b0, n)) begin
                    errors++;
                    $display("FAIL sweep_msb v=%h beat=%0d got=%h want=%h", v, n, obs_b, exp_out(v, 1'b0, n));
                end
                code_ready = 1'($urandom_range(0, 1));
                if (code_ready) n++;
                if (code_ready && code_valid_a) dut_beats++;
                @(negedge clk);
            end
            checks++;
            if (dut_beats !== k) begin
                errors++;
                $display("FAIL sweep_beats v=%h got=%0d want=%0d", v, dut_beats, k);
            end
            checks++;
            if ({req_ready_a, req_ready_b, obs_a, obs_b} !== {2'b11, 20'd0}) begin
                errors++;
                $display("FAIL sweep_idle v=%h got=%h want=%h", v, {req_ready_a, req_ready_b, obs_a, obs_b}, {2'b11, 20'd0});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_multibit();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
